// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two master request ports and the data-memory port seen by dmem_port_arbiter.
// Handshake: a master holds mX_req_i with stable fields until its one-cycle mX_ack_o; memory completes with a one-cycle mem_ack_i.
interface dmem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            m0_req_i;
  logic            m0_w_en_i;
  logic [XLEN-1:0] m0_addr_i;
  logic [XLEN-1:0] m0_w_data_i;
  logic            m0_kill_i;
  logic            m0_ack_o;
  logic [XLEN-1:0] m0_r_data_o;

  logic            m1_req_i;
  logic            m1_w_en_i;
  logic [XLEN-1:0] m1_addr_i;
  logic [XLEN-1:0] m1_w_data_i;
  logic            m1_ack_o;
  logic [XLEN-1:0] m1_r_data_o;

  logic            mem_req_o;
  logic            mem_w_en_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_w_data_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_r_data_i;

  logic            bus_err_o;

  // Arbiter side
  modport slave (
    input  m0_req_i, m0_w_en_i, m0_addr_i, m0_w_data_i, m0_kill_i,
    output m0_ack_o, m0_r_data_o,
    input  m1_req_i, m1_w_en_i, m1_addr_i, m1_w_data_i,
    output m1_ack_o, m1_r_data_o,
    output mem_req_o, mem_w_en_o, mem_addr_o, mem_w_data_o,
    input  mem_ack_i, mem_r_data_i,
    output bus_err_o
  );

  // Environment side: the two masters plus the data memory
  modport master (
    output m0_req_i, m0_w_en_i, m0_addr_i, m0_w_data_i, m0_kill_i,
    input  m0_ack_o, m0_r_data_o,
    output m1_req_i, m1_w_en_i, m1_addr_i, m1_w_data_i,
    input  m1_ack_o, m1_r_data_o,
    input  mem_req_o, mem_w_en_o, mem_addr_o, mem_w_data_o,
    output mem_ack_i, mem_r_data_i,
    input  bus_err_o
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the dcache path (M0) and the
// victim-cache writeback path (M1); one full req/ack transaction per grant, all outputs registered.
module dmem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus,
  output logic [1:0]           dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic            r_rr;
  logic [1:0]      r_mask;
  logic            r_owner;
  logic            r_killed;
  logic [7:0]      r_timer;
  logic            r_mem_req;
  logic            r_mem_w_en;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_w_data;
  logic            r_ack0;
  logic            r_ack1;
  logic [XLEN-1:0] r_r_data0;
  logic [XLEN-1:0] r_r_data1;
  logic            r_err;

  logic [1:0]      w_elig;
  logic            w_grant;
  logic            w_sel;
  logic            w_kill_now;
  logic [XLEN-1:0] w_resp_data;

  // The mask keeps a master that still shows req in the cycle after its ack from being regranted.
  assign w_elig  = {bus.m1_req_i, bus.m0_req_i} & ~r_mask;
  assign w_grant = |w_elig;
  assign w_sel   = (w_elig == 2'b11) ? r_rr : w_elig[1];

  assign w_kill_now  = r_killed | (~r_owner & bus.m0_kill_i);
  assign w_resp_data = r_mem_w_en ? '0 : bus.mem_r_data_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr         <= 1'b0;
      r_mask       <= 2'b00;
      r_owner      <= 1'b0;
      r_killed     <= 1'b0;
      r_timer      <= 8'd0;
      r_mem_req    <= 1'b0;
      r_mem_w_en   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_w_data <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_r_data0    <= '0;
      r_r_data1    <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mask <= 2'b00;
          if (w_grant) begin
            r_owner      <= w_sel;
            r_mem_req    <= 1'b1;
            r_mem_w_en   <= w_sel ? bus.m1_w_en_i   : bus.m0_w_en_i;
            r_mem_addr   <= w_sel ? bus.m1_addr_i   : bus.m0_addr_i;
            r_mem_w_data <= w_sel ? bus.m1_w_data_i : bus.m0_w_data_i;
            r_timer      <= 8'd0;
            r_killed     <= ~w_sel & bus.m0_kill_i;
            r_state      <= S_BUSY;
          end
        end

        S_BUSY: begin
          if (~r_owner & bus.m0_kill_i) begin
            r_killed <= 1'b1;
          end
          if (bus.mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_rr      <= ~r_owner;
            r_state   <= S_RESP;
            if (r_owner) begin
              r_ack1    <= 1'b1;
              r_r_data1 <= w_resp_data;
            end else if (!w_kill_now) begin
              r_ack0    <= 1'b1;
              r_r_data0 <= w_resp_data;
            end
          end else begin
            // No abort on timeout: flag it and keep waiting for memory.
            if (r_timer != TO_MAX) begin
              r_timer <= r_timer + 8'd1;
            end
            if (r_timer == TO_LAST) begin
              r_err <= 1'b1;
            end
          end
        end

        S_RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_mask  <= r_owner ? 2'b10 : 2'b01;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_o    = r_mem_req;
  assign bus.mem_w_en_o   = r_mem_w_en;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_w_data_o = r_mem_w_data;
  assign bus.m0_ack_o     = r_ack0;
  assign bus.m1_ack_o     = r_ack1;
  assign bus.m0_r_data_o  = r_r_data0;
  assign bus.m1_r_data_o  = r_r_data1;
  assign bus.bus_err_o    = r_err;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_dmem_port_arbiter;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.XLEN(XLEN)) bus ();
  logic [1:0] dbg_state;

  dmem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // ---------------- masters ----------------
  // A master requests while it has more issued transactions than acks seen, or while held.
  bit m0_hold = 1'b0, m1_hold = 1'b0;
  int m0_issue = 0, m1_issue = 0;
  int m0_ack_cnt = 0, m1_ack_cnt = 0;
  assign bus.m0_req_i = m0_hold || (m0_issue > m0_ack_cnt);
  assign bus.m1_req_i = m1_hold || (m1_issue > m1_ack_cnt);

  // ---------------- memory responder ----------------
  bit          mem_auto  = 1'b0;
  int          ack_delay = 2;
  logic [31:0] mem_base  = 32'hDEADBEEF;
  int          mem_cnt   = 0;
  int          mem_seq   = 0;

  always @(negedge clk) begin
    if (bus.mem_ack_i === 1'b1) begin
      bus.mem_ack_i = 1'b0;
    end else begin
      bus.mem_ack_i = 1'b0;
      if (mem_auto && bus.mem_req_o) begin
        mem_cnt++;
        if (mem_cnt >= ack_delay) begin
          bus.mem_ack_i    = 1'b1;
          bus.mem_r_data_i = mem_base + 32'(mem_seq) * 32'h0101_0101;
          mem_seq++;
          mem_cnt = 0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mo_owner   = -1;  // master holding the port, -1 when free
  bit          mo_resp    = 1'b0;
  bit          mo_killed  = 1'b0;
  int          mo_waited  = 0;
  int          mo_blocked = -1;
  int          mo_pref    = 0;
  logic        e_mem_req, e_w_en, e_ack0, e_ack1, e_err;
  logic [31:0] e_addr, e_wdata, e_rdata0, e_rdata1;

  task automatic model_step();
    bit want0, want1;
    int g;
    if (rst) begin
      mo_owner = -1; mo_resp = 0; mo_killed = 0; mo_waited = 0; mo_blocked = -1; mo_pref = 0;
      e_mem_req = 0; e_w_en = 0; e_addr = 0; e_wdata = 0;
      e_ack0 = 0; e_ack1 = 0; e_rdata0 = 0; e_rdata1 = 0; e_err = 0;
    end else if (mo_owner >= 0 && !mo_resp) begin
      if (mo_owner == 0 && bus.m0_kill_i) mo_killed = 1;
      if (bus.mem_ack_i) begin
        e_mem_req = 0;
        mo_resp   = 1;
        mo_pref   = 1 - mo_owner;
        if (mo_owner == 1) begin
          e_ack1 = 1; e_rdata1 = e_w_en ? 32'h0 : bus.mem_r_data_i;
        end else if (!mo_killed) begin
          e_ack0 = 1; e_rdata0 = e_w_en ? 32'h0 : bus.mem_r_data_i;
        end
      end else begin
        mo_waited++;
        if (mo_waited >= TIMEOUT) e_err = 1;
      end
    end else if (mo_resp) begin
      e_ack0 = 0; e_ack1 = 0;
      mo_resp = 0;
      mo_blocked = mo_owner;
      mo_owner = -1;
    end else begin
      want0 = bus.m0_req_i && mo_blocked != 0;
      want1 = bus.m1_req_i && mo_blocked != 1;
      mo_blocked = -1;
      if (want0 || want1) begin
        g = (want0 && want1) ? mo_pref : (want0 ? 0 : 1);
        mo_owner  = g;
        e_mem_req = 1;
        e_w_en    = g ? bus.m1_w_en_i   : bus.m0_w_en_i;
        e_addr    = g ? bus.m1_addr_i   : bus.m0_addr_i;
        e_wdata   = g ? bus.m1_w_data_i : bus.m0_w_data_i;
        mo_waited = 0;
        mo_killed = (g == 0) && bus.m0_kill_i;
      end
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];   // grant address log, compared against hand-computed order
  logic        grant_we[$];
  logic [31:0] grant_wd[$];
  int          grant_cyc[$];
  bit          prev_req = 0, prev_err = 0, prev_ack0 = 0;
  bit          mem_ack_seen;
  int          mem_ack_cnt = 0, both_ack = 0;
  int          memack_cyc = 0, ack0_cyc = 0, err_cyc = 0;

  always @(posedge clk) begin
    mem_ack_seen = (bus.mem_ack_i === 1'b1);
    if (mem_ack_seen) begin
      memack_cyc = cycle;
      mem_ack_cnt++;
    end
    model_step();
    #1;
    cycle++;
    check("mem_req", bus.mem_req_o, e_mem_req);
    if (e_mem_req) begin
      check("mem_w_en", bus.mem_w_en_o, e_w_en);
      check("mem_addr", bus.mem_addr_o, e_addr);
      check("mem_w_data", bus.mem_w_data_o, e_wdata);
    end
    check("m0_ack", bus.m0_ack_o, e_ack0);
    check("m1_ack", bus.m1_ack_o, e_ack1);
    check("m0_r_data", bus.m0_r_data_o, e_rdata0);
    check("m1_r_data", bus.m1_r_data_o, e_rdata1);
    check("bus_err", bus.bus_err_o, e_err);

    if (bus.mem_req_o && !prev_req) begin
      exp_q.push_back(bus.mem_addr_o);
      grant_we.push_back(bus.mem_w_en_o);
      grant_wd.push_back(bus.mem_w_data_o);
      grant_cyc.push_back(cycle);
    end
    if (bus.bus_err_o && !prev_err) err_cyc = cycle;
    if (bus.m0_ack_o && !prev_ack0) ack0_cyc = cycle;
    if (bus.m0_ack_o) m0_ack_cnt++;
    if (bus.m1_ack_o) m1_ack_cnt++;
    if (bus.m0_ack_o && bus.m1_ack_o) both_ack++;
    prev_req  = bus.mem_req_o;
    prev_err  = bus.bus_err_o;
    prev_ack0 = bus.m0_ack_o;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grants(input int n, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() >= n) return;
    end
    checks++; errors++;
    $display("FAIL %s: timeout, grants %0d required %0d", name, exp_q.size(), n);
  endtask

  task automatic wait_acks(input int n0, input int n1, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (m0_ack_cnt >= n0 && m1_ack_cnt >= n1) return;
    end
    checks++; errors++;
    $display("FAIL %s: timeout, acks %0d/%0d required %0d/%0d", name, m0_ack_cnt, m1_ack_cnt, n0, n1);
  endtask

  task automatic set_m0(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.m0_w_en_i = we; bus.m0_addr_i = addr; bus.m0_w_data_i = wd;
  endtask

  task automatic set_m1(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.m1_w_en_i = we; bus.m1_addr_i = addr; bus.m1_w_data_i = wd;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int g, a0, a1, ma;
    set_m0(0, 0, 0);
    set_m1(0, 0, 0);
    bus.m0_kill_i    = 1'b0;
    bus.mem_r_data_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_mem_req", bus.mem_req_o, 0);
    check("reset_bus_err", bus.bus_err_o, 0);
    check("reset_m0_ack", bus.m0_ack_o, 0);

    // 1: lone M0 read, memory acks 2 cycles after request
    mem_auto = 1; ack_delay = 2; mem_base = 32'hDEADBEEF;
    set_m0(0, 32'h14, 0);
    m0_issue = m0_ack_cnt + 1;
    wait_acks(1, 0, 30, "t1_ack");
    idle(3);
    check("t1_addr", exp_q[0], 32'h14);
    check("t1_w_en", grant_we[0], 0);
    check("t1_r_data", bus.m0_r_data_o, 32'hDEADBEEF);
    check("t1_ack_latency", ack0_cyc - memack_cyc, 1);
    check("t1_ack_count", m0_ack_cnt, 1);

    // 2: simultaneous requests after reset, M0 first
    pulse_reset();
    g = exp_q.size(); a0 = m0_ack_cnt; a1 = m1_ack_cnt;
    set_m0(0, 32'h10, 0);
    set_m1(1, 32'hC000_0010, 32'h4);
    m0_issue = a0 + 1; m1_issue = a1 + 1;
    wait_acks(a0 + 1, a1 + 1, 40, "t2_ack");
    idle(3);
    check("t2_first_addr", exp_q[g], 32'h10);
    check("t2_second_addr", exp_q[g + 1], 32'hC000_0010);
    check("t2_second_w_en", grant_we[g + 1], 1);
    check("t2_second_w_data", grant_wd[g + 1], 32'h4);
    check("t2_acks_together", both_ack, 0);

    // 3: both hold requests continuously, grants alternate
    g = exp_q.size();
    set_m0(0, 32'h100, 0);
    set_m1(0, 32'h200, 0);
    m0_hold = 1; m1_hold = 1;
    wait_grants(g + 4, 60, "t3_grants");
    m0_hold = 0; m1_hold = 0;
    m0_issue = m0_ack_cnt; m1_issue = m1_ack_cnt;
    idle(12);
    check("t3_grant0", exp_q[g],     32'h100);
    check("t3_grant1", exp_q[g + 1], 32'h200);
    check("t3_grant2", exp_q[g + 2], 32'h100);
    check("t3_grant3", exp_q[g + 3], 32'h200);

    // 4: M0 read killed mid-flight; M1 then served, then M0 again
    g = exp_q.size(); a0 = m0_ack_cnt; a1 = m1_ack_cnt; ma = mem_ack_cnt;
    ack_delay = 4;
    set_m0(0, 32'h300, 0);
    set_m1(1, 32'h400, 32'hABCD);
    m0_issue = a0 + 1; m1_issue = a1 + 1;
    wait_grants(g + 1, 20, "t4_grant");
    bus.m0_kill_i = 1'b1;
    @(negedge clk);
    bus.m0_kill_i = 1'b0;
    wait_acks(a0 + 1, a1 + 1, 80, "t4_ack");
    idle(8);
    check("t4_grant0", exp_q[g],     32'h300);
    check("t4_grant1", exp_q[g + 1], 32'h400);
    check("t4_grant2", exp_q[g + 2], 32'h300);
    check("t4_grant_count", exp_q.size() - g, 3);
    check("t4_m0_acks", m0_ack_cnt - a0, 1);
    check("t4_mem_acks", mem_ack_cnt - ma, 3);

    // 5: memory never acks, bus_err_o after TIMEOUT cycles
    g = exp_q.size();
    mem_auto = 0;
    set_m0(0, 32'h500, 0);
    m0_issue = m0_ack_cnt + 1;
    wait_grants(g + 1, 10, "t5_grant");
    idle(14);
    check("t5_err_delay", err_cyc - grant_cyc[g], TIMEOUT);
    check("t5_err_sticky", bus.bus_err_o, 1);
    check("t5_req_held", bus.mem_req_o, 1);
    check("t5_addr_held", bus.mem_addr_o, 32'h500);

    // 6: reset during BUSY, then simultaneous requests grant M0
    m0_issue = m0_ack_cnt;
    pulse_reset();
    check("t6_mem_req", bus.mem_req_o, 0);
    check("t6_bus_err", bus.bus_err_o, 0);
    check("t6_m0_ack", bus.m0_ack_o, 0);
    check("t6_m1_ack", bus.m1_ack_o, 0);
    g = exp_q.size(); a0 = m0_ack_cnt; a1 = m1_ack_cnt;
    mem_auto = 1; ack_delay = 1;
    set_m0(0, 32'h600, 0);
    set_m1(0, 32'h700, 0);
    m0_issue = a0 + 1; m1_issue = a1 + 1;
    wait_acks(a0 + 1, a1 + 1, 40, "t6_ack");
    idle(4);
    check("t6_first_grant", exp_q[g], 32'h600);
    check("t6_second_grant", exp_q[g + 1], 32'h700);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
